// File: rtl/hdr_exposure_sequencer.sv
// HDR exposure bracket sequencer: steps a programmable AEC table once per frame and
// arbitrates manual, COM8 and exposure writes onto one config-engine request port.
// Build option EXP_FULL_AEC_EN: the exposure write becomes 3 bytes (07/10/04) instead of 10 only.
// state     | meaning
// IDLE      | pick next pending write (man > com8 > exp), load address/data
// ISSUE     | cfg_start pulse, busy asserted
// WAIT_DONE | hold address/data until cfg_done
// NEXT      | load following byte of a multi-byte exposure write
module hdr_exposure_sequencer #(
  parameter int          NUM_EXP   = 3,
  parameter int          IDX_W     = 3,
  parameter int          FRAME_LAG = 2,
  parameter logic [15:0] EXP_STEP  = 16'h0150
) (
  input  logic             clk_25M,
  input  logic             rst_n,
  input  logic             man_start,
  input  logic [7:0]       man_addr,
  input  logic [7:0]       man_data,
  input  logic             hdr_en,
  input  logic             change_exp,
  input  logic             tbl_we,
  input  logic [IDX_W-1:0] tbl_idx,
  input  logic [15:0]      tbl_val,
  output logic             cfg_start,
  output logic [7:0]       cfg_addr,
  output logic [7:0]       cfg_data,
  input  logic             cfg_done,
  output logic [IDX_W-1:0] cur_idx,
  output logic [IDX_W-1:0] frame_tag,
  output logic [7:0]       overrun_cnt,
  output logic             busy
);

  localparam int               TBL_N     = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_EXP - 1);
  localparam logic [7:0]       COM8_ADDR = 8'h13;
  localparam logic [7:0]       COM8_ON   = 8'hC4;
  localparam logic [7:0]       COM8_OFF  = 8'hC5;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, NEXT} state_t;

  state_t           state_q;
  logic             man_start_q, hdr_en_q;
  logic             man_pend_q, com8_pend_q, exp_pend_q;
  logic [7:0]       man_addr_q, man_data_q, com8_data_q;
  logic [15:0]      tbl_q [TBL_N];
  logic [IDX_W-1:0] cur_idx_q, cur_idx_d;
  logic [IDX_W-1:0] tag_q [FRAME_LAG];
  logic [7:0]       overrun_q;
  logic [7:0]       cfg_addr_q, cfg_data_q;
  logic             cfg_start_q, busy_q;

  logic             man_rise, hdr_rise, hdr_edge, exp_evt;
  logic             pick_man, pick_com8, pick_exp;
  logic [15:0]      sel_val;
  logic [7:0]       first_addr, first_data;
  logic             exp_last;

`ifdef EXP_FULL_AEC_EN
  // Only the low 10 bits are needed after the first byte has been issued.
  logic [9:0]       exp_val_q;
  logic [1:0]       byte_q, byte_d;
  logic [7:0]       next_addr, next_data;

  always_comb begin
    byte_d    = byte_q + 2'd1;
    next_addr = 8'h04;
    next_data = {6'b0, exp_val_q[1:0]};
    if (byte_d == 2'd1) begin
      next_addr = 8'h10;
      next_data = exp_val_q[9:2];
    end
  end

  assign first_addr = 8'h07;
  assign first_data = {2'b00, sel_val[15:10]};
  assign exp_last   = (byte_q == 2'd2);
`else
  logic unused_sel_bits;
  assign unused_sel_bits = ^{sel_val[15:10], sel_val[1:0]};
  assign first_addr = 8'h10;
  assign first_data = sel_val[9:2];
  assign exp_last   = 1'b1;
`endif

  always_comb begin
    man_rise  = man_start & ~man_start_q;
    hdr_rise  = hdr_en & ~hdr_en_q;
    hdr_edge  = hdr_en ^ hdr_en_q;
    exp_evt   = change_exp & hdr_en;
    pick_man  = (state_q == IDLE) & man_pend_q;
    pick_com8 = (state_q == IDLE) & ~man_pend_q & com8_pend_q;
    pick_exp  = (state_q == IDLE) & ~man_pend_q & ~com8_pend_q & exp_pend_q;
    sel_val   = tbl_q[cur_idx_q];
    cur_idx_d = '0;
    if (hdr_en && cur_idx_q != LAST_IDX) cur_idx_d = cur_idx_q + 1'b1;
  end

  always_ff @(posedge clk_25M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      man_start_q <= 1'b0;
      hdr_en_q    <= 1'b0;
      man_pend_q  <= 1'b0;
      com8_pend_q <= 1'b0;
      exp_pend_q  <= 1'b0;
      man_addr_q  <= '0;
      man_data_q  <= '0;
      com8_data_q <= '0;
      cur_idx_q   <= '0;
      overrun_q   <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      cfg_start_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i < TBL_N; i++) tbl_q[i] <= 16'(EXP_STEP * (i + 1));
      for (int j = 0; j < FRAME_LAG; j++) tag_q[j] <= '0;
`ifdef EXP_FULL_AEC_EN
      exp_val_q   <= '0;
      byte_q      <= '0;
`endif
    end else begin
      man_start_q <= man_start;
      hdr_en_q    <= hdr_en;
      cfg_start_q <= 1'b0;

      if (tbl_we && tbl_idx <= LAST_IDX) tbl_q[tbl_idx] <= tbl_val;

      if (man_rise) begin
        man_addr_q <= man_addr;
        man_data_q <= man_data;
      end
      if (hdr_edge) com8_data_q <= hdr_rise ? COM8_ON : COM8_OFF;

      if (change_exp) begin
        cur_idx_q <= cur_idx_d;
        tag_q[0]  <= cur_idx_q;
        for (int j = FRAME_LAG - 1; j > 0; j--) tag_q[j] <= tag_q[j-1];
      end

      // A pending exposure write being taken this cycle is not a skipped one.
      if (exp_evt && exp_pend_q && !pick_exp && overrun_q != 8'hFF)
        overrun_q <= overrun_q + 8'd1;

      // New events win over the clear of a flag that is consumed in the same cycle.
      man_pend_q  <= man_rise | (man_pend_q & ~pick_man);
      com8_pend_q <= hdr_edge | (com8_pend_q & ~pick_com8);
      exp_pend_q  <= exp_evt | (exp_pend_q & ~pick_exp);

      case (state_q)
        IDLE: begin
          if (pick_man) begin
            cfg_addr_q <= man_addr_q;
            cfg_data_q <= man_data_q;
          end else if (pick_com8) begin
            cfg_addr_q <= COM8_ADDR;
            cfg_data_q <= com8_data_q;
          end else if (pick_exp) begin
            cfg_addr_q <= first_addr;
            cfg_data_q <= first_data;
          end
`ifdef EXP_FULL_AEC_EN
          if (pick_exp) begin
            exp_val_q <= sel_val[9:0];
            byte_q    <= 2'd0;
          end else begin
            byte_q    <= 2'd2;
          end
`endif
          if (pick_man || pick_com8 || pick_exp) begin
            state_q     <= ISSUE;
            cfg_start_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        ISSUE: begin
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (cfg_done) begin
            if (exp_last) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        NEXT: begin
`ifdef EXP_FULL_AEC_EN
          byte_q     <= byte_d;
          cfg_addr_q <= next_addr;
          cfg_data_q <= next_data;
`endif
          state_q     <= ISSUE;
          cfg_start_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_start   = cfg_start_q;
  assign cfg_addr    = cfg_addr_q;
  assign cfg_data    = cfg_data_q;
  assign busy        = busy_q;
  assign cur_idx     = cur_idx_q;
  assign frame_tag   = tag_q[FRAME_LAG-1];
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_hdr_exposure_sequencer.sv
// Directed bench for hdr_exposure_sequencer: bracket stepping, frame tags, arbitration,
// overrun counting, table writes and reset mid-transaction. Honours EXP_FULL_AEC_EN.
module tb_hdr_exposure_sequencer;

  logic       clk_25M = 1'b0;
  logic       rst_n;
  logic       man_start;
  logic [7:0] man_addr, man_data;
  logic       hdr_en, change_exp, tbl_we;
  logic [2:0] tbl_idx;
  logic [15:0] tbl_val;
  logic       cfg_start;
  logic [7:0] cfg_addr, cfg_data;
  logic       cfg_done;
  logic [2:0] cur_idx, frame_tag;
  logic [7:0] overrun_cnt;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_tbl [3];
  logic [15:0] wr;

`ifdef EXP_FULL_AEC_EN
  localparam int N_WR = 3;
`else
  localparam int N_WR = 1;
`endif

  hdr_exposure_sequencer dut (
    .clk_25M(clk_25M), .rst_n(rst_n),
    .man_start(man_start), .man_addr(man_addr), .man_data(man_data),
    .hdr_en(hdr_en), .change_exp(change_exp),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_val(tbl_val),
    .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_done(cfg_done),
    .cur_idx(cur_idx), .frame_tag(frame_tag), .overrun_cnt(overrun_cnt), .busy(busy)
  );

  always #20 clk_25M = ~clk_25M;

  // {addr, data} of byte n of the exposure write for AEC value v.
  function automatic logic [15:0] exp_wr(input int n, input logic [15:0] v);
`ifdef EXP_FULL_AEC_EN
    case (n)
      0:       return {8'h07, 2'b00, v[15:10]};
      1:       return {8'h10, v[9:2]};
      default: return {8'h04, 6'b0, v[1:0]};
    endcase
`else
    return (n == 0) ? {8'h10, v[9:2]} : 16'h0000;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_start(input string tag, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    while (cfg_start !== 1'b1 && n < 50) begin
      @(negedge clk_25M);
      n++;
    end
    check({tag, "_start"}, 32'(cfg_start), 32'd1);
    check({tag, "_addr"}, 32'(cfg_addr), 32'(a));
    check({tag, "_data"}, 32'(cfg_data), 32'(d));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic give_done(input string tag, input bit last);
    @(negedge clk_25M);
    check({tag, "_start1cyc"}, 32'(cfg_start), 32'd0);
    cfg_done = 1'b1;
    @(negedge clk_25M);
    cfg_done = 1'b0;
    check({tag, "_busy_after"}, 32'(busy), last ? 32'd0 : 32'd1);
  endtask

  task automatic serve(input string tag, input logic [7:0] a, input logic [7:0] d);
    wait_start(tag, a, d);
    give_done(tag, 1'b1);
  endtask

  task automatic serve_exp(input string tag, input logic [15:0] v);
    logic [15:0] w;
    for (int n = 0; n < N_WR; n++) begin
      w = exp_wr(n, v);
      wait_start($sformatf("%s_b%0d", tag, n), w[15:8], w[7:0]);
      give_done($sformatf("%s_b%0d", tag, n), n == N_WR - 1);
    end
  endtask

  task automatic frame_evt(input string tag, input logic [2:0] exp_cur, input logic [2:0] exp_tag);
    change_exp = 1'b1;
    @(negedge clk_25M);
    change_exp = 1'b0;
    tbl_we     = 1'b0;
    check({tag, "_cur_idx"}, 32'(cur_idx), 32'(exp_cur));
    check({tag, "_frame_tag"}, 32'(frame_tag), 32'(exp_tag));
    @(negedge clk_25M);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_25M);
      if (cfg_start === 1'b1) seen++;
    end
    check({tag, "_no_start"}, 32'(seen), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cfg_start"}, 32'(cfg_start), 32'd0);
    check({tag, "_cfg_addr"}, 32'(cfg_addr), 32'd0);
    check({tag, "_cfg_data"}, 32'(cfg_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cur_idx"}, 32'(cur_idx), 32'd0);
    check({tag, "_frame_tag"}, 32'(frame_tag), 32'd0);
    check({tag, "_overrun"}, 32'(overrun_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; hdr_en = 1'b1; man_start = 1'b0; man_addr = '0; man_data = '0;
    change_exp = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_val = '0; cfg_done = 1'b0;
    model_tbl[0] = 16'h0150; model_tbl[1] = 16'h02A0; model_tbl[2] = 16'h03F0;
    repeat (3) @(negedge clk_25M);
    check_zero("reset");
    rst_n = 1'b1;

    // hdr_en already high at reset release counts as a rise
    serve("com8_boot", 8'h13, 8'hC4);
    frame_evt("e1", 3'd1, 3'd0); serve_exp("e1", model_tbl[1]);
    frame_evt("e2", 3'd2, 3'd0); serve_exp("e2", model_tbl[2]);
    frame_evt("e3", 3'd0, 3'd1); serve_exp("e3", model_tbl[0]);
    frame_evt("e4", 3'd1, 3'd2); serve_exp("e4", model_tbl[1]);

    // arbitration: manual beats COM8 when both arrive together
    hdr_en = 1'b0; serve("com8_fall0", 8'h13, 8'hC5);
    hdr_en = 1'b1; man_start = 1'b1; man_addr = 8'h3A; man_data = 8'h04;
    serve("man", 8'h3A, 8'h04);
    serve("com8_rise", 8'h13, 8'hC4);
    man_start = 1'b0;
    hdr_en = 1'b0; serve("com8_fall", 8'h13, 8'hC5);
    frame_evt("e5_off", 3'd0, 3'd0);
    quiet("e5_off", 20);
    hdr_en = 1'b1; serve("com8_rise2", 8'h13, 8'hC4);

    // overrun: two frame events while cfg_done is withheld
    frame_evt("e6", 3'd1, 3'd1);
    wr = exp_wr(0, model_tbl[1]); wait_start("e6_b0", wr[15:8], wr[7:0]);
    frame_evt("e7", 3'd2, 3'd0);
    check("e7_overrun", 32'(overrun_cnt), 32'd0);
    frame_evt("e8", 3'd0, 3'd1);
    check("e8_overrun", 32'(overrun_cnt), 32'd1);
    give_done("e6_b0", N_WR == 1);
    for (int n = 1; n < N_WR; n++) begin
      wr = exp_wr(n, model_tbl[1]);
      wait_start($sformatf("e6_b%0d", n), wr[15:8], wr[7:0]);
      give_done($sformatf("e6_b%0d", n), n == N_WR - 1);
    end
    serve_exp("e8_newest", model_tbl[0]);
    quiet("ovr_single", 20);
    check("ovr_final", 32'(overrun_cnt), 32'd1);

    // table write in the same cycle as a frame event, then snapshot behaviour
    tbl_we = 1'b1; tbl_idx = 3'd0; tbl_val = 16'hFFFF; model_tbl[0] = 16'hFFFF;
    frame_evt("e9_we", 3'd1, 3'd2); serve_exp("e9", model_tbl[1]);
    frame_evt("e10", 3'd2, 3'd0);   serve_exp("e10", model_tbl[2]);
    frame_evt("e11", 3'd0, 3'd1);
    wr = exp_wr(0, 16'hFFFF); wait_start("e11_b0", wr[15:8], wr[7:0]);
    tbl_we = 1'b1; tbl_idx = 3'd0; tbl_val = 16'h0004;
    @(negedge clk_25M);
    tbl_we = 1'b0;
    give_done("e11_b0", N_WR == 1);
    for (int n = 1; n < N_WR; n++) begin
      wr = exp_wr(n, 16'hFFFF);
      wait_start($sformatf("e11_b%0d", n), wr[15:8], wr[7:0]);
      give_done($sformatf("e11_b%0d", n), n == N_WR - 1);
    end

    // reset while waiting for cfg_done, with a manual write pending
    frame_evt("e12", 3'd1, 3'd2);
    wr = exp_wr(0, model_tbl[1]); wait_start("e12_b0", wr[15:8], wr[7:0]);
    @(negedge clk_25M);
    man_start = 1'b1; man_addr = 8'h55; man_data = 8'h66;
    @(negedge clk_25M);
    man_start = 1'b0;
    #5 rst_n = 1'b0; hdr_en = 1'b0;
    #1 check_zero("mid_rst");
    @(negedge clk_25M);
    rst_n = 1'b1;
    cfg_done = 1'b1;
    @(negedge clk_25M);
    cfg_done = 1'b0;
    quiet("post_rst", 20);
    check("post_rst_busy", 32'(busy), 32'd0);

    model_tbl[0] = 16'h0150;
    hdr_en = 1'b1; serve("com8_rst", 8'h13, 8'hC4);
    frame_evt("r1", 3'd1, 3'd0); serve_exp("r1", model_tbl[1]);
    frame_evt("r2", 3'd2, 3'd0); serve_exp("r2", model_tbl[2]);
    frame_evt("r3", 3'd0, 3'd1); serve_exp("r3", model_tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
